// File: rtl/bidir_half_duplex_responder.sv
// Single-wire half-duplex responder: receive a request frame, leave the line
// idle for a turnaround gap, then drive a response frame from a handshake.

module bidir_half_duplex_responder #(
  parameter int DATA_W       = 8,
  parameter int BIT_CYCLES   = 16,
  parameter int TURN_CYCLES  = 32,
  parameter int RESP_TIMEOUT = 256
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BIDIR_I,
  output logic              BIDIR_O,
  output logic              BIDIR_OE,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              FRAME_ERR,
  output logic              TX_READY,
  input  logic              TX_VALID,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              TIMEOUT
);

  localparam int CM1 =
    (TURN_CYCLES > BIT_CYCLES) ? TURN_CYCLES : BIT_CYCLES;
  localparam int CMAX =
    (RESP_TIMEOUT > CM1) ? RESP_TIMEOUT : CM1;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] HALF_L = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] BIT_L  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] TURN_L = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] TOUT_L = CW'(RESP_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_L  = IW'(DATA_W - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RX_START,
    S_RX_DATA,
    S_RX_STOP,
    S_TURN,
    S_WAIT_TX,
    S_TX_START,
    S_TX_DATA,
    S_TX_STOP,
    S_TX_GUARD
  } state_e;

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] txsh_q, txsh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              tx_ready_q, tx_ready_d;
  logic              timeout_q, timeout_d;
  logic              oe_q, oe_d;
  logic              o_q, o_d;
  logic [1:0]        sync_q;
  logic              rx_prev_q;

  logic rx;
  logic rx_fall;
  logic bit_end;
  logic turn_end;

  assign rx       = sync_q[1];
  assign rx_fall  = rx_prev_q & ~rx;
  assign bit_end  = (cnt_q == BIT_L);
  assign turn_end = (cnt_q == TURN_L);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], BIDIR_I};
      rx_prev_q <= sync_q[1];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    shift_d     = shift_q;
    txsh_d      = txsh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    tx_ready_d  = tx_ready_q;
    timeout_d   = 1'b0;
    oe_d        = oe_q;
    o_d         = o_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_fall) state_d = S_RX_START;
      end
      S_RX_START: begin
        if (cnt_q == HALF_L) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx ? S_IDLE : S_RX_DATA;
        end
      end
      S_RX_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[DATA_W-1:1]};
          idx_d   = idx_q + IW'(1);
          if (idx_q == IDX_L) state_d = S_RX_STOP;
        end
      end
      S_RX_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (rx) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_TURN;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_TURN: begin
        if (turn_end) begin
          cnt_d      = '0;
          tx_ready_d = 1'b1;
          state_d    = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        // A handshake on the last waiting cycle still wins over the timeout.
        if (TX_VALID && tx_ready_q) begin
          cnt_d      = '0;
          txsh_d     = TX_DATA;
          tx_ready_d = 1'b0;
          oe_d       = 1'b1;
          o_d        = 1'b0;
          state_d    = S_TX_START;
        end else if (cnt_q == TOUT_L) begin
          cnt_d      = '0;
          tx_ready_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_TX_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          o_d     = txsh_q[0];
          state_d = S_TX_DATA;
        end
      end
      S_TX_DATA: begin
        if (bit_end) begin
          cnt_d  = '0;
          idx_d  = idx_q + IW'(1);
          txsh_d = txsh_q >> 1;
          if (idx_q == IDX_L) begin
            o_d     = 1'b1;
            state_d = S_TX_STOP;
          end else begin
            o_d = txsh_d[0];
          end
        end
      end
      S_TX_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          oe_d    = 1'b0;
          o_d     = 1'b1;
          state_d = S_TX_GUARD;
        end
      end
      S_TX_GUARD: begin
        if (turn_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      txsh_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      timeout_q   <= 1'b0;
      oe_q        <= 1'b0;
      o_q         <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      txsh_q      <= txsh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      tx_ready_q  <= tx_ready_d;
      timeout_q   <= timeout_d;
      oe_q        <= oe_d;
      o_q         <= o_d;
    end
  end

  assign BIDIR_O   = o_q;
  assign BIDIR_OE  = oe_q;
  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign FRAME_ERR = frame_err_q;
  assign TX_READY  = tx_ready_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_bidir_half_duplex_responder.sv
// Bench for bidir_half_duplex_responder: randomized request/response frames
// against a per-cycle expectation timeline built from frame timing arithmetic.

module tb_bidir_half_duplex_responder;

  localparam int DW   = 8;
  localparam int BC   = 16;
  localparam int TC   = 32;
  localparam int RT   = 256;
  localparam int MAXC = 30000;
  // sync (2) + state entry (1) + half bit + nine bit periods + pulse register
  localparam int RXV = 2 + 1 + (BC / 2 - 1) + 9 * BC + 1;
  localparam int RDY = RXV + TC;
  localparam int TXB = (DW + 2) * BC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bidir_i = 1'b1;
  logic          bidir_o;
  logic          bidir_oe;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          tx_ready;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          timeout;

  bidir_half_duplex_responder #(
    .DATA_W(DW), .BIT_CYCLES(BC),
    .TURN_CYCLES(TC), .RESP_TIMEOUT(RT)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .BIDIR_I(bidir_i), .BIDIR_O(bidir_o), .BIDIR_OE(bidir_oe),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .FRAME_ERR(frame_err),
    .TX_READY(tx_ready), .TX_VALID(tx_valid), .TX_DATA(tx_data),
    .TIMEOUT(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          e_oe [MAXC];
  logic          e_o  [MAXC];
  logic          e_rv [MAXC];
  logic          e_fe [MAXC];
  logic          e_rdy[MAXC];
  logic          e_to [MAXC];
  logic [DW-1:0] e_rxd[MAXC];

  typedef struct {
    int t;
    int kind;
    int val;
  } lit_t;
  lit_t lits[$];

  bit chk_en = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;
  int to_cnt = 0;
  int rdy_cnt = 0;
  int oe_cnt = 0;

  task automatic check(input string nm, input int t,
                       input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, t, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      if (rx_valid === 1'b1) rv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
      if (timeout === 1'b1) to_cnt++;
      if (tx_ready === 1'b1) rdy_cnt++;
      if (bidir_oe === 1'b1) oe_cnt++;
      check("cycle {oe,o,rv,fe,rdy,to,rxd}", cyc,
        32'({bidir_oe, bidir_o, rx_valid, frame_err,
             tx_ready, timeout, rx_data}),
        32'({e_oe[cyc], e_o[cyc], e_rv[cyc], e_fe[cyc],
             e_rdy[cyc], e_to[cyc], e_rxd[cyc]}));
      foreach (lits[i]) begin
        if (lits[i].t == cyc) begin
          case (lits[i].kind)
            1: check("rx_data", cyc, 32'(rx_data), 32'(lits[i].val));
            2: check("rx_valid_count", cyc, 32'(rv_cnt), 32'(lits[i].val));
            3: check("frame_err_count", cyc, 32'(fe_cnt), 32'(lits[i].val));
            4: check("timeout_count", cyc, 32'(to_cnt), 32'(lits[i].val));
            5: check("tx_ready_cycles", cyc, 32'(rdy_cnt), 32'(lits[i].val));
            6: check("oe_high_cycles", cyc, 32'(oe_cnt), 32'(lits[i].val));
            7: check("tx_bit", cyc, 32'(bidir_o), 32'(lits[i].val));
            default: check("line_released", cyc,
                           32'({bidir_oe, bidir_o}), 32'(lits[i].val));
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bidir_i = 1'b1;
    tx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_from(input int t);
    for (int i = t; i < MAXC; i++) begin
      e_oe[i] = 1'b0; e_o[i] = 1'b1; e_rv[i] = 1'b0; e_fe[i] = 1'b0;
      e_rdy[i] = 1'b0; e_to[i] = 1'b0; e_rxd[i] = '0;
    end
  endtask

  task automatic add_lit(input int t, input int kind, input int val);
    lit_t l;
    l.t = t; l.kind = kind; l.val = val;
    lits.push_back(l);
  endtask

  // One request frame and whatever response/timeout follows it.
  task automatic xact(input logic [DW-1:0] d, input bit stop, input bit hs,
                      input int dly, input logic [DW-1:0] txd,
                      input bit early, input int rst_off,
                      input bit pin, input logic [9:0] pseq);
    int k, rs, c, fin, rst_t, off;
    logic [9:0] fr;
    logic [9:0] tf;
    logic v;
    k  = cyc;
    fr = {stop, d, 1'b0};
    tf = {1'b1, txd, 1'b0};
    rs = k + RDY;
    c  = early ? rs : rs + dly;
    if (stop) begin
      e_rv[k+RXV] = 1'b1;
      for (int i = k + RXV; i < MAXC; i++) e_rxd[i] = d;
      if (pin) begin
        add_lit(k + RXV + 1, 1, int'(d));
        add_lit(k + RXV + 5, 2, rv_cnt + 1);
      end
      if (hs) begin
        for (int i = rs; i <= c; i++) e_rdy[i] = 1'b1;
        for (int i = 0; i < TXB; i++) begin
          e_oe[c+1+i] = 1'b1;
          e_o[c+1+i]  = tf[i/BC];
        end
        fin = c + 1 + TXB + TC;
        if (pin) begin
          for (int j = 0; j < 10; j++)
            add_lit(c + 1 + BC * j + BC / 2, 7, int'(pseq[j]));
          add_lit(c + TXB + 30, 6, oe_cnt + TXB);
        end
      end else begin
        for (int i = rs; i < rs + RT; i++) e_rdy[i] = 1'b1;
        e_to[rs+RT] = 1'b1;
        fin = rs + RT + 1;
        if (pin) begin
          add_lit(rs + RT, 5, rdy_cnt + RT);
          add_lit(rs + RT, 4, to_cnt + 1);
          add_lit(rs + RT, 6, oe_cnt);
        end
      end
    end else begin
      e_fe[k+RXV] = 1'b1;
      fin = k + 10 * BC;
      if (pin) begin
        add_lit(fin - 1, 3, fe_cnt + 1);
        add_lit(fin - 1, 2, rv_cnt);
      end
    end
    rst_t = (stop && hs && rst_off >= 0) ? c + 1 + rst_off : -1;
    for (int t = k; t < fin; t++) begin
      off = t - k;
      if (off < 10 * BC) v = fr[off/BC];
      else if (stop && off < 11 * BC) v = 1'b0;
      else if (stop && hs && t > c && t <= c + TXB) v = 1'($urandom);
      else if (stop && hs && t >= c + TXB + 5 && t < c + TXB + 21) v = 1'b0;
      else v = 1'b1;
      bidir_i  = v;
      tx_valid = stop && hs && (t == c || (early && t >= k + 170 && t < c));
      tx_data  = tx_valid ? txd : DW'($urandom);
      if (t == rst_t) begin
        #2;
        rst_n = 1'b0;
        clear_from(t);
        add_lit(t, 8, 1);
        idle(5);
        rst_n = 1'b1;
        break;
      end
      tick();
    end
    idle(20);
  endtask

  task automatic glitch();
    int k;
    k = cyc;
    bidir_i = 1'b0;
    repeat (4) tick();
    idle(30);
    add_lit(cyc, 2, rv_cnt);
    add_lit(cyc, 3, fe_cnt);
    if (k < 0) $display("unreachable");
  endtask

  initial begin
    #(MAXC * 10 + 1000);
    $display("FAIL watchdog: run exceeded %0d cycles", MAXC);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d, txd;
    bit stop, hs, early;
    int dly;
    clear_from(0);
    repeat (3) tick();
    chk_en = 1'b1;
    repeat (5) tick();
    rst_n = 1'b1;
    idle(100);
    add_lit(cyc, 8, 1);
    add_lit(cyc, 2, 0);
    add_lit(cyc, 3, 0);
    add_lit(cyc, 4, 0);
    idle(2);

    xact(8'hA5, 1, 1, 10, 8'h3C, 0, -1, 1, 10'b1001111000);
    glitch();
    xact(8'h5A, 1, 1, 0, 8'h81, 1, -1, 1, 10'b1100000010);
    xact(8'hFF, 0, 0, 0, 8'h00, 0, -1, 1, 10'b0);
    xact(8'h33, 1, 0, 0, 8'h00, 0, -1, 1, 10'b0);
    xact(8'hC7, 1, 1, RT - 1, 8'hE1, 0, -1, 1, 10'b1111000010);
    xact(8'h96, 1, 1, 20, 8'h55, 0, 4 * BC + 5, 0, 10'b0);
    idle(20);
    xact(8'h6E, 1, 1, 3, 8'h00, 0, -1, 1, 10'b1000000000);

    for (int n = 0; n < 8; n++) begin
      d     = DW'($urandom);
      txd   = DW'($urandom);
      stop  = ($urandom % 4) != 0;
      hs    = ($urandom % 3) != 0;
      early = ($urandom % 4) == 0;
      dly   = int'($urandom_range(0, RT - 1));
      xact(d, stop, hs, dly, txd, early, -1, 1, {1'b1, txd, 1'b0});
      idle(int'($urandom_range(1, 40)));
    end

    idle(10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bidir_half_duplex_responder.md
Name: bidir_half_duplex_responder

Overview:
- Far-end peer of a registered bidirectional pad: a single-wire, half-duplex serial responder.
- Receives a request frame from an initiator on the shared line, then waits a turnaround gap.
- Drives a response frame from a user handshake, then releases the line.
- Sits between the pad primitives (input buffer output, tri-state buffer I/OE) and user logic.

Parameters:
DATA_W, 8, payload bits per frame, LSB first
BIT_CYCLES, 16, clocks per bit; even, >=4
TURN_CYCLES, 32, clocks the line is left undriven between request stop-bit sample and response window
RESP_TIMEOUT, 256, max clocks TX_READY waits for TX_VALID

Ports:
CLK  input  1  single clock
RST_N  input  1  asynchronous active-low reset
BIDIR_I  input  1  line level from pad input buffer; idle level 1
BIDIR_O  output  1  value to pad tri-state data
BIDIR_OE  output  1  pad tri-state enable; 1 = responder drives line
RX_DATA  output  DATA_W  last received payload
RX_VALID  output  1  one-cycle pulse, RX_DATA valid
FRAME_ERR  output  1  one-cycle pulse, request stop bit sampled 0
TX_READY  output  1  high while waiting for response data
TX_VALID  input  1  response data offered
TX_DATA  input  DATA_W  response payload, captured on TX_VALID&TX_READY
TIMEOUT  output  1  one-cycle pulse, no TX_VALID within RESP_TIMEOUT

Behaviour:
- Reset (async assert, sync deassert via internal flops): BIDIR_OE=0, BIDIR_O=1, RX_DATA=0, RX_VALID=0, FRAME_ERR=0, TX_READY=0, TIMEOUT=0, state IDLE, sync flops=1.
- BIDIR_I passes a 2-flop synchronizer; all RX decisions use the synchronized value. Added latency is 2 clocks.
- Frame format is 1 start (0), DATA_W data bits LSB first, 1 stop (1). Each bit lasts BIT_CYCLES.
- States: IDLE, RX_START, RX_DATA, RX_STOP, TURN, WAIT_TX, TX_START, TX_DATA, TX_STOP, TX_GUARD.
- IDLE -> RX_START on a synchronized 1->0 edge. Bit counter cleared on the edge cycle.
- RX_START sample at count BIT_CYCLES/2-1:
  - 0: go to RX_DATA.
  - 1: glitch, return to IDLE with no pulses.
- Data and stop samples are taken every BIT_CYCLES after the start sample (mid-bit).
- RX_STOP sample:
  - 1: RX_DATA updated, RX_VALID pulses the next cycle, go to TURN.
  - 0: FRAME_ERR pulses, RX_DATA unchanged; IDLE re-arms only once the line has read 1 for at least one cycle.
- TURN: BIDIR_OE=0 for exactly TURN_CYCLES, then WAIT_TX.
- WAIT_TX: TX_READY=1.
  - On TX_VALID&TX_READY: capture TX_DATA, TX_READY=0 next cycle, go to TX_START.
  - After RESP_TIMEOUT cycles without handshake: TIMEOUT pulses, go to IDLE, line never driven.
  - TX_VALID on the exact timeout cycle: handshake wins.
- TX: BIDIR_O and BIDIR_OE are registered.
  - OE rises with the first start-bit cycle.
  - Each bit is held exactly BIT_CYCLES.
  - Stop bit drives 1.
  - OE falls the cycle after the stop bit ends.
  - Total OE-high time is (DATA_W+2)*BIT_CYCLES.
- TX_GUARD: line undriven and ignored for TURN_CYCLES, then IDLE.
- Initiator edges seen in any TX or TURN state are ignored; no RX starts outside IDLE.
- BIDIR_OE and BIDIR_O never change in the same cycle as a reset assertion other than to their reset values. Reset mid-frame immediately releases the line (OE=0) and discards partial data.

Test Plan:
1. Hold RST_N=0 then release, line=1 for 100 cycles -> BIDIR_OE=0, BIDIR_O=1, no pulses.
2. Initiator sends 0xA5 with stop=1 -> exactly one RX_VALID with RX_DATA=0xA5; BIDIR_OE=0 for >=32 cycles after the stop sample; TX_READY then rises.
3. Following test 2, TX_VALID=1 with TX_DATA=0x3C -> BIDIR_OE=1 for 160 cycles. Line sequence at 16 cycles/bit is 0,0,0,1,1,1,1,0,0,1. OE then drops, and initiator edges in the next 32 cycles are ignored.
4. Line pulled low 4 cycles then high -> no RX_VALID, no FRAME_ERR, state returns to IDLE; a following valid 0x5A frame is received correctly.
5. Frame 0xFF with stop=0 -> FRAME_ERR pulse, no RX_VALID, BIDIR_OE stays 0. Next: valid frame, TX_VALID held 0 -> TIMEOUT pulses 256 cycles after TX_READY rises, OE stays 0.
6. RST_N asserted at bit 4 of a TX frame -> BIDIR_OE=0 asynchronously, BIDIR_O=1. After release, a new request is received normally.
